// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Optional trailing checksum byte is enabled by defining INST_LOADER_CHECKSUM_EN.
package inst_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR,
        CHK
    } state_e;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Collects little-endian bytes into one instruction word; word_full_o is high
// for exactly the cycle after the fourth byte is accepted, until cleared.
module byte_assembler
    import inst_loader_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             accept_i,
    input  logic [BYTE_W-1:0]                byte_i,
    output logic [BYTES_PER_WORD*BYTE_W-1:0] word_o,
    output logic [1:0]                       byte_cnt_o,
    output logic                             word_full_o
);

    logic [BYTES_PER_WORD*BYTE_W-1:0] word_q, word_d;
    logic [1:0]                       cnt_q, cnt_d;
    logic                             full_q, full_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clear_i) begin
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (accept_i) begin
            word_d[BYTE_W*cnt_q +: BYTE_W] = byte_i;
            cnt_d  = cnt_q + 2'd1;
            full_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign word_o      = word_q;
    assign byte_cnt_o  = cnt_q;
    assign word_full_o = full_q;

endmodule

// File: rtl/inst_loader.sv
// Streams program bytes into instruction memory and holds the core in reset
// until loaded. Define INST_LOADER_CHECKSUM_EN for the trailing XOR check byte.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 80,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [LEN_W-1:0]  prog_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WORD_W-1:0] mem_wr_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             asm_clear, asm_accept, asm_full;
    logic [1:0]       asm_cnt;
    logic             len_bad;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]       xor_q, xor_d;
`endif

    byte_assembler u_asm (
        .clk_i       (CLK),
        .rst_i       (RST),
        .clear_i     (asm_clear),
        .accept_i    (asm_accept),
        .byte_i      (byte_data),
        .word_o      (mem_wr_data),
        .byte_cnt_o  (asm_cnt),
        .word_full_o (asm_full)
    );

    assign len_bad = (prog_len == '0) || (prog_len > LEN_W'(DEPTH));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        asm_clear  = 1'b0;
        asm_accept = 1'b0;
        byte_ready = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    if (len_bad) begin
                        state_d = ERR;
                    end else begin
                        state_d    = RECV;
                        len_d      = prog_len;
                        word_cnt_d = '0;
                        asm_clear  = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                        xor_d      = '0;
`endif
                    end
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    asm_accept = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ byte_data;
`endif
                    if (asm_cnt == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                asm_clear  = 1'b1;
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q == len_q - 1'b1) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_d = (byte_data == xor_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they change on
        // the same edge as the state itself.
        cpu_rst_d = (state_d != DONE);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    // The assembler's full flag is high exactly during WRITE, so it doubles as
    // the registered write strobe; word_cnt_q holds the current index there.
    assign mem_wr_en   = asm_full;
    assign mem_wr_addr = ADDR_W'({word_cnt_q, 2'b00});
    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed, table-driven bench for inst_loader (default and checksum builds).
module tb_inst_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] prog_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_wr_en, cpu_rst, done, err;
    logic [63:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  xacc;

    typedef struct {
        logic [15:0] len;
        logic [31:0] stim;      // bytes in send order, first byte in [31:24]
        logic        gap;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    inst_loader #(.WORD_W(32), .DEPTH(80), .ADDR_W(64), .LEN_W(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .prog_len    (prog_len),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mem_wr_en === 1'b1) begin
            wa_q.push_back(mem_wr_addr);
            wd_q.push_back(mem_wr_data);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gap);
        if (gap) begin
            byte_valid = 1'b0;
            tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && byte_ready !== 1'b1; i++) tick();
        if (byte_ready !== 1'b1) check("byte_ready_timeout", {63'd0, byte_ready}, 64'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input logic gap);
        xacc ^= b;
        send_byte(b, gap);
    endtask

    task automatic do_start(input logic [15:0] len);
        wa_q.delete();
        wd_q.delete();
        xacc     = '0;
        start    = 1'b1;
        prog_len = len;
        tick();
        start    = 1'b0;
    endtask

    // Called with the DUT in the final WRITE cycle.
    task automatic finish_load();
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(xacc, 1'b0);
`else
        tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;

        vecs[0] = '{len: 16'd0,     stim: 32'h0,        gap: 1'b0, exp_err: 1'b1, exp_data: 32'h0};
        vecs[1] = '{len: 16'd81,    stim: 32'h0,        gap: 1'b0, exp_err: 1'b1, exp_data: 32'h0};
        vecs[2] = '{len: 16'd1,     stim: 32'h93005000, gap: 1'b0, exp_err: 1'b0, exp_data: 32'h00500093};
        vecs[3] = '{len: 16'd1,     stim: 32'h13A0B0C0, gap: 1'b1, exp_err: 1'b0, exp_data: 32'hC0B0A013};
        vecs[4] = '{len: 16'hFFFF,  stim: 32'h0,        gap: 1'b0, exp_err: 1'b1, exp_data: 32'h0};
        vecs[5] = '{len: 16'd1,     stim: 32'hDEADBEEF, gap: 1'b0, exp_err: 1'b0, exp_data: 32'hEFBEADDE};

        // Reset values
        tick(); tick();
        check("rst_cpu_rst",    {63'd0, cpu_rst},    64'd1);
        check("rst_done",       {63'd0, done},       64'd0);
        check("rst_err",        {63'd0, err},        64'd0);
        check("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
        check("rst_wr_en",      {63'd0, mem_wr_en},  64'd0);
        check("rst_wr_addr",    mem_wr_addr,         64'd0);
        check("rst_wr_data",    {32'd0, mem_wr_data}, 64'd0);
        RST = 1'b0;
        tick();

        // Table: length errors, single-word loads, recovery from ERR/DONE
        for (int v = 0; v < 6; v++) begin
            do_start(vecs[v].len);
            if (vecs[v].exp_err) begin
                check("vec_err",        {63'd0, err},        64'd1);
                check("vec_err_cpurst", {63'd0, cpu_rst},    64'd1);
                check("vec_err_done",   {63'd0, done},       64'd0);
                check("vec_err_ready",  {63'd0, byte_ready}, 64'd0);
                tick(); tick();
                check("vec_err_nowrite", 64'(wd_q.size()), 64'd0);
            end else begin
                check("vec_err_clear",  {63'd0, err},        64'd0);
                check("vec_cpurst_hi",  {63'd0, cpu_rst},    64'd1);
                check("vec_ready",      {63'd0, byte_ready}, 64'd1);
                s = vecs[v].stim;
                for (int b = 3; b >= 0; b--) send_data(s[8*b +: 8], vecs[v].gap);
                check("vec_wr_en",   {63'd0, mem_wr_en},   64'd1);
                check("vec_wr_addr", mem_wr_addr,          64'd0);
                check("vec_wr_data", {32'd0, mem_wr_data}, {32'd0, vecs[v].exp_data});
                finish_load();
                check("vec_done",    {63'd0, done},    64'd1);
                check("vec_cpu_run", {63'd0, cpu_rst}, 64'd0);
                check("vec_nwrites", 64'(wd_q.size()), 64'd1);
            end
        end

        // Gapped two-word load
        do_start(16'd2);
        send_data(8'h11, 1'b1); send_data(8'h22, 1'b1); send_data(8'h33, 1'b1); send_data(8'h44, 1'b1);
        send_data(8'h55, 1'b1); send_data(8'h66, 1'b1); send_data(8'h77, 1'b1); send_data(8'h88, 1'b1);
        finish_load();
        check("gap_done",    {63'd0, done},    64'd1);
        check("gap_nwrites", 64'(wd_q.size()), 64'd2);
        if (wd_q.size() == 2) begin
            check("gap_addr0", wa_q[0], 64'd0);
            check("gap_data0", {32'd0, wd_q[0]}, 64'h44332211);
            check("gap_addr1", wa_q[1], 64'd4);
            check("gap_data1", {32'd0, wd_q[1]}, 64'h88776655);
        end

        // Maximum-length load (80 words)
        do_start(16'd80);
        for (int w = 0; w < 80; w++) begin
            send_data(8'(w), 1'b0);
            send_data(8'(w) ^ 8'hA5, 1'b0);
            send_data(8'h5A, 1'b0);
            send_data(8'hC3, 1'b0);
        end
        finish_load();
        check("max_done",    {63'd0, done},    64'd1);
        check("max_nwrites", 64'(wd_q.size()), 64'd80);
        for (int w = 0; w < 80 && w < wd_q.size(); w++) begin
            check("max_addr", wa_q[w], 64'(w * 4));
            check("max_data", {32'd0, wd_q[w]}, {32'd0, 8'hC3, 8'h5A, 8'(w) ^ 8'hA5, 8'(w)});
        end
        check("max_last_addr", wa_q[$], 64'h13C);

        // Mid-load reset after two bytes of word 1
        do_start(16'd2);
        send_data(8'h01, 1'b0); send_data(8'h02, 1'b0); send_data(8'h03, 1'b0); send_data(8'h04, 1'b0);
        send_data(8'h05, 1'b0); send_data(8'h06, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_cpurst", {63'd0, cpu_rst},    64'd1);
        check("mid_ready",  {63'd0, byte_ready}, 64'd0);
        check("mid_done",   {63'd0, done},       64'd0);
        check("mid_wr_en",  {63'd0, mem_wr_en},  64'd0);
        tick(); tick(); tick();
        check("mid_nwrites", 64'(wd_q.size()), 64'd1);
        check("mid_addr0",   wa_q[0],          64'd0);

`ifdef INST_LOADER_CHECKSUM_EN
        // Trailer checks
        do_start(16'd1);
        send_data(8'h13, 1'b0); send_data(8'h00, 1'b0); send_data(8'h00, 1'b0); send_data(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        check("chk_ok_done", {63'd0, done}, 64'd1);
        check("chk_ok_err",  {63'd0, err},  64'd0);
        do_start(16'd1);
        send_data(8'h13, 1'b0); send_data(8'h00, 1'b0); send_data(8'h00, 1'b0); send_data(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("chk_bad_err",    {63'd0, err},     64'd1);
        check("chk_bad_cpurst", {63'd0, cpu_rst}, 64'd1);
        check("chk_bad_done",   {63'd0, done},    64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
